// File: rtl/decoupled_fetch_unit.sv
// Decoupled instruction fetch front end: PC generation, gshare + BTB
// prediction, one-cycle imem interface and a decoupling fetch queue.
module decoupled_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter int              GHR_BITS    = 8,
    parameter int              BTB_ENTRIES = 256,
    parameter int              QDEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                globalResetN,
    output logic                imemReq,
    output logic [XLEN-1:0]     imemAddr,
    input  logic [XLEN-1:0]     imemData,
    input  logic                decodeRedirect,
    input  logic [XLEN-1:0]     decodeTarget,
    input  logic                commitValid,
    input  logic                commitBranch,
    input  logic                commitTaken,
    input  logic                commitMispredict,
    input  logic [XLEN-1:0]     commitPC,
    input  logic [XLEN-1:0]     commitTarget,
    input  logic [GHR_BITS-1:0] commitIndex,
    input  logic [1:0]          commitState,
    output logic                fqValid,
    input  logic                fqReady,
    output logic [XLEN-1:0]     fqInstr,
    output logic [XLEN-1:0]     fqPC,
    output logic [XLEN-1:0]     fqPredPC,
    output logic [GHR_BITS-1:0] fqIndex,
    output logic [1:0]          fqState,
    output logic                fqPredTaken
);
    localparam int BIW  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - BIW - 2;
    localparam int QW   = $clog2(QDEPTH);
    localparam int CW   = QW + 1;
    localparam int PHTN = 1 << GHR_BITS;

    typedef struct packed {
        logic [XLEN-1:0]     instr;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     predpc;
        logic [GHR_BITS-1:0] idx;
        logic [1:0]          state;
        logic                taken;
    } fq_entry_t;

    logic [XLEN-1:0]     pc;
    logic [GHR_BITS-1:0] ghr;
    logic [1:0]          pht [PHTN];
    logic [BTB_ENTRIES-1:0] btbValid;
    logic [TAGW-1:0]     btbTag [BTB_ENTRIES];
    logic [XLEN-1:0]     btbTarget [BTB_ENTRIES];
    logic                inFlight;
    logic [XLEN-1:0]     mPC, mPredPC;
    logic [GHR_BITS-1:0] mIdx;
    logic [1:0]          mState;
    logic                mTaken;
    fq_entry_t           q [QDEPTH];
    fq_entry_t           head;
    logic [QW-1:0]       rptr, wptr;
    logic [CW-1:0]       count;

    logic                flush, train, issue, push, pop, predHit;
    logic [GHR_BITS-1:0] lkIdx;
    logic [1:0]          lkState;
    logic [BIW-1:0]      bIdx, cIdx;
    logic [TAGW-1:0]     bTag, cTag;
    logic [XLEN-1:0]     predPC;
    logic [3:0]          unused_bits;

    assign unused_bits = {commitPC[1:0], pc[1:0]};

    assign flush   = (commitValid & commitMispredict) | decodeRedirect;
    assign train   = commitValid & commitBranch;
    assign lkIdx   = pc[GHR_BITS+1:2] ^ ghr;
    assign lkState = pht[lkIdx];
    assign bIdx    = pc[BIW+1:2];
    assign bTag    = pc[XLEN-1:BIW+2];
    assign cIdx    = commitPC[BIW+1:2];
    assign cTag    = commitPC[XLEN-1:BIW+2];
    assign predHit = btbValid[bIdx] & (btbTag[bIdx] == bTag) & lkState[1];
    assign predPC  = predHit ? btbTarget[bIdx] : pc + XLEN'(4);
    assign issue   = globalResetN & ~flush
                   & ((count + CW'(inFlight)) < CW'(QDEPTH));
    assign push    = inFlight & ~flush;
    assign fqValid = globalResetN & (count != '0);
    assign pop     = fqValid & fqReady;
    assign head    = fqValid ? q[rptr] : '0;

    assign imemReq     = issue;
    assign imemAddr    = pc;
    assign fqInstr     = head.instr;
    assign fqPC        = head.pc;
    assign fqPredPC    = head.predpc;
    assign fqIndex     = head.idx;
    assign fqState     = head.state;
    assign fqPredTaken = head.taken;

    // PC selection, global history and request metadata for the response
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            pc       <= RESET_PC;
            ghr      <= '0;
            inFlight <= 1'b0;
            mPC      <= '0;
            mPredPC  <= '0;
            mIdx     <= '0;
            mState   <= '0;
            mTaken   <= 1'b0;
        end else begin
            if (commitValid & commitMispredict)
                pc <= commitTarget;
            else if (decodeRedirect)
                pc <= decodeTarget;
            else if (issue)
                pc <= predPC;
            if (train)
                ghr <= {ghr[GHR_BITS-2:0], commitTaken};
            inFlight <= issue;
            if (issue) begin
                mPC     <= pc;
                mPredPC <= predPC;
                mIdx    <= lkIdx;
                mState  <= lkState;
                mTaken  <= predHit;
            end
        end
    end

    // Direction counters are overwritten with the value resolved at commit
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            for (int i = 0; i < PHTN; i++)
                pht[i] <= 2'b01;
        end else if (train) begin
            pht[commitIndex] <= commitState;
        end
    end

    // BTB valid bits; only taken committed branches allocate
    always_ff @(posedge clk) begin
        if (!globalResetN)
            btbValid <= '0;
        else if (train & commitTaken)
            btbValid[cIdx] <= 1'b1;
    end

    // BTB tag/target payload, qualified by the valid bits above
    always_ff @(posedge clk) begin
        if (train & commitTaken) begin
            btbTag[cIdx]    <= cTag;
            btbTarget[cIdx] <= commitTarget;
        end
    end

    // Fetch queue pointers and occupancy; a flush empties it
    always_ff @(posedge clk) begin
        if (!globalResetN || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + QW'(1);
            if (pop)
                rptr <= rptr + QW'(1);
            if (push & ~pop)
                count <= count + CW'(1);
            else if (pop & ~push)
                count <= count - CW'(1);
        end
    end

    // Fetch queue storage: returning word joined with its metadata
    always_ff @(posedge clk) begin
        if (globalResetN && push)
            q[wptr] <= '{imemData, mPC, mPredPC, mIdx, mState, mTaken};
    end
endmodule

// File: doc/decoupled_fetch_unit.md
# decoupled_fetch_unit

Parametrised next-generation instruction fetch front end: PC generation with redirect priority, a gshare direction predictor, and a tagged direct-mapped BTB, feeding a decoupling fetch queue toward rename/decode. Unlike the single-register fetch stage, it drives an external instruction memory with fixed one-cycle read latency. Fetched instructions and their prediction metadata are buffered in a QDEPTH-entry FIFO with a valid/ready handshake, so decode back-pressure no longer freezes the whole front end.

## Interface
- XLEN, 32, address/instruction width
- GHR_BITS, 8, global history length; PHT holds 2^GHR_BITS 2-bit counters
- BTB_ENTRIES, 256, BTB entries (power of 2); index = PC[log2(BTB_ENTRIES)+1:2], tag = remaining upper PC bits
- QDEPTH, 4, fetch-queue entries (power of 2, >=2)
- RESET_PC, 0, PC after reset
- clk  in  1  single clock, all state on rising edge
- globalResetN  in  1  synchronous, active-low reset
- imemReq  out  1  fetch issued this cycle
- imemAddr  out  XLEN  fetch address (= PC register)
- imemData  in  XLEN  instruction for the address issued the previous cycle
- decodeRedirect  in  1  JAL resolved at decode, redirect
- decodeTarget  in  XLEN  JAL target
- commitValid  in  1  commit bus entry valid
- commitBranch  in  1  committed op is a conditional branch/JAL (trains predictor)
- commitTaken  in  1  resolved direction
- commitMispredict  in  1  flush and redirect
- commitPC  in  XLEN  PC of committed op
- commitTarget  in  XLEN  resolved target / restart address
- commitIndex  in  GHR_BITS  PHT index carried with the op
- commitState  in  2  new counter value for PHT[commitIndex]
- fqValid  out  1  queue head valid
- fqReady  in  1  decode accepts head
- fqInstr, fqPC, fqPredPC  out  XLEN  head instruction, its PC, predicted next PC
- fqIndex  out  GHR_BITS  PHT index used
- fqState  out  2  PHT counter read
- fqPredTaken  out  1  fetch was steered by prediction

## Operation
- Next PC priority: commitValid&commitMispredict -> commitTarget; else decodeRedirect -> decodeTarget; else if issuing and predHit -> BTB target; else if issuing -> PC+4; else hold.
- Lookup on the PC register, combinational: index = PC[GHR_BITS+1:2] ^ GHR; predHit = BTB valid & tag match & PHT[index][1].
- Issue condition: no flush/redirect this cycle and count + inFlight < QDEPTH; imemReq = issue. inFlight is a 1-bit register set by issue.
- Metadata {PC, predPC, index, state, predTaken} is registered with the request; on the next cycle, if inFlight and not killed, {imemData, metadata} is pushed.
- Flush (commit mispredict or decode redirect): clear queue (count=0, pointers to 0), clear inFlight so the returning response is dropped, load the new PC; no issue this cycle.
- Training: commitValid&commitBranch -> PHT[commitIndex] <= commitState, GHR <= {GHR[GHR_BITS-2:0], commitTaken}. If commitTaken is also set, BTB[commitPC] <= {valid, tag, commitTarget}. Training also occurs in a flush cycle.
- Queue: circular with read/write pointers and a count of width log2(QDEPTH)+1. Pop when fqValid&fqReady. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo QDEPTH.
- Reset: PC=RESET_PC, GHR=0, all PHT=2'b01, all BTB valid=0, queue empty, inFlight=0.

## Timing
- Request in cycle t; the entry is written at the end of t+1 and is visible on fq* in t+2 when the queue was empty (no bypass).
- Sustained throughput is 1 instruction/cycle while fqReady=1.
- fq* are driven from the head entry; they are don't-care but held 0 while fqValid=0. All outputs are 0 during and after reset except imemAddr=RESET_PC.
- imemReq is first asserted in the cycle after reset deasserts.
- Flush takes effect on the edge. The first request to the new PC is in cycle flush+1, and fqValid=0 in cycle flush+1.
- Training is visible to lookups on the following cycle. Same-cycle read and write to an entry returns the old value.
- Full: count + inFlight = QDEPTH -> imemReq=0, PC holds. No entry is ever dropped or overwritten.

## Test plan
- Reset, RESET_PC=0x100, fqReady=1, imem returns addr-based words -> imemAddr 0x100,0x104,0x108... on consecutive cycles; fqValid from cycle 3; fqPC sequence matches; fqPredTaken=0.
- fqReady=0 with QDEPTH=4 -> exactly 4 entries queued, imemReq low and PC stable. Release fqReady -> entries drain in order with no gap or duplicate.
- Train: commit branch at 0x108, taken, target 0x200, commitState=2'b11, matching index. Refetch from 0x100 -> after 0x108, imemAddr=0x200; entry 0x108 has fqPredPC=0x200, fqPredTaken=1.
- decodeRedirect to 0x400 with 3 entries queued and one in flight -> queue empty next cycle, in-flight data discarded, next fqPC=0x400.
- Same cycle: commitMispredict to 0x80 and decodeRedirect to 0x400 -> PC=0x80. GHR shifts commitTaken in if commitBranch.
- globalResetN low mid-stream with a full queue -> after one cycle fqValid=0, GHR=0, BTB misses, PC=RESET_PC.
